// File: rtl/acess_pkg.sv
// rtl/acess_pkg.sv - shared types, constants and sizing helper for the password-table scan controller
package acess_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    GRANT = 3'd2,
    DENY  = 3'd3,
    LOCK  = 3'd4
  } state_e;

  localparam logic [7:0] EMPTY_ENTRY = 8'h00;

  function automatic int timer_width(input int hold, input int lock);
    int m;
    m = (hold > lock) ? hold : lock;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/acess_scan_ctrl_if.sv
// rtl/acess_scan_ctrl_if.sv - request, ROM and status signals between the scan controller and its neighbours
interface acess_scan_ctrl_if #(
  parameter int AW = 5
);
  logic          enter;
  logic [7:0]    senha;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_q;
  logic          busy;
  logic          granted;
  logic          denied;
  logic          locked;

  modport master (
    input  enter, senha, rom_q,
    output rom_addr, busy, granted, denied, locked
  );

  modport slave (
    output enter, senha, rom_q,
    input  rom_addr, busy, granted, denied, locked
  );
endinterface

// File: rtl/acess_timer.sv
// rtl/acess_timer.sv - loadable down-counter shared by the hold and lockout phases
module acess_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // done marks the last cycle of the loaded window so the FSM leaves on that edge
  assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/acess_scan_ctrl.sv
// rtl/acess_scan_ctrl.sv - password ROM scan sequencer with grant/deny hold; LOCKOUT_EN adds the lockout phase
module acess_scan_ctrl
  import acess_pkg::*;
#(
  parameter int AW          = 5,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              clr_n,
  acess_scan_ctrl_if.master bus
);
  localparam int            DEPTH     = 2 ** AW;
  localparam int            TW        = timer_width(HOLD_CYCLES, LOCK_CYCLES);
  localparam int            FW        = $clog2(MAX_FAILS + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]    senha_q, senha_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic          entry_match;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  assign entry_match = cmp_vld_q && (bus.rom_q == senha_q) && (bus.rom_q != EMPTY_ENTRY);

  always_comb begin
    state_d    = state_q;
    senha_d    = senha_q;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = rom_addr_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.enter) begin
          senha_d = bus.senha;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cmp_vld_d = 1'b1;
        // compare result is registered once; first hit wins over any later entry
        hit_d  = !hit_q && !miss_q && entry_match;
        miss_d = !hit_q && !miss_q && cmp_vld_q && !entry_match && (cmp_addr_q == LAST_ADDR);
        if (hit_q) begin
          state_d = GRANT;
        end else if (miss_q) begin
          state_d = DENY;
          if (fail_cnt_q != FW'(MAX_FAILS))
            fail_cnt_d = fail_cnt_q + 1'b1;
        end
      end
      GRANT: begin
        if (tmr_done) begin
          state_d    = IDLE;
          fail_cnt_d = '0;
        end
      end
      DENY: begin
        if (tmr_done) begin
`ifdef LOCKOUT_EN
          state_d = (fail_cnt_q == FW'(MAX_FAILS)) ? LOCK : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      LOCK: begin
`ifdef LOCKOUT_EN
        if (tmr_done) begin
          state_d    = IDLE;
          fail_cnt_d = '0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_addr_d = '0;
    if (state_q == SCAN && state_d == SCAN)
      rom_addr_d = (rom_addr_q == LAST_ADDR) ? LAST_ADDR : rom_addr_q + 1'b1;
  end

  assign tmr_load  = (state_d != state_q) &&
                     (state_d == GRANT || state_d == DENY || state_d == LOCK);
  assign tmr_value = (state_d == LOCK) ? TW'(LOCK_CYCLES) : TW'(HOLD_CYCLES);

  acess_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (clr_n),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      senha_q    <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      senha_q    <= senha_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.granted  = (state_q == GRANT);
  assign bus.denied   = (state_q == DENY);
`ifdef LOCKOUT_EN
  assign bus.locked   = (state_q == LOCK);
`else
  assign bus.locked   = 1'b0;
`endif
endmodule

// File: tb/tb_acess_scan_ctrl.sv
// tb/tb_acess_scan_ctrl.sv - directed-vector bench for acess_scan_ctrl with a behavioural synchronous ROM
module tb_acess_scan_ctrl;
  localparam int AW          = 5;
  localparam int HOLD_CYCLES = 8;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 1000;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  acess_scan_ctrl_if #(.AW(AW)) bus ();

  acess_scan_ctrl #(
    .AW(AW), .HOLD_CYCLES(HOLD_CYCLES), .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  logic [7:0] rom_mem [32];
  always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int g_edge, d_edge, l_edge, g_len, d_len, l_len, g_rises, addr5, both;

  task automatic request(input logic [7:0] pw, input int inj_a, input int inj_b, input int win);
    logic prev_g;
    g_edge = -1; d_edge = -1; l_edge = -1;
    g_len = 0; d_len = 0; l_len = 0; g_rises = 0; addr5 = -1; both = 0;
    prev_g = 1'b0;
    bus.senha = pw;
    bus.enter = 1'b1;
    @(posedge clk); #1;
    bus.enter = 1'b0;
    for (int e = 1; e <= win; e++) begin
      @(posedge clk); #1;
      bus.enter = 1'b0;
      if (e == 5) addr5 = int'(bus.rom_addr);
      if (bus.granted) begin
        if (g_edge < 0) g_edge = e;
        g_len++;
        if (!prev_g) g_rises++;
      end
      prev_g = bus.granted;
      if (bus.denied) begin
        if (d_edge < 0) d_edge = e;
        d_len++;
      end
      if (bus.locked) begin
        if (l_edge < 0) l_edge = e;
        l_len++;
      end
      if (bus.granted && bus.denied) both++;
      if (e == inj_a || e == inj_b) bus.enter = 1'b1;
    end
    bus.enter = 1'b0;
  endtask

  initial begin
    int lock_total, lock_grants, quiet_hits;
    clr_n     = 1'b0;
    bus.enter = 1'b0;
    bus.senha = 8'h00;
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'h80 + 8'(i);
    rom_mem[0]  = 8'h00;
    rom_mem[5]  = 8'hA7;
    rom_mem[20] = 8'hA7;
    rom_mem[31] = 8'h55;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",     32'(bus.busy),        0);
    check_eq("rst_granted",  32'(bus.granted),     0);
    check_eq("rst_denied",   32'(bus.denied),      0);
    check_eq("rst_locked",   32'(bus.locked),      0);
    check_eq("rst_rom_addr", 32'(bus.rom_addr),    0);
    check_eq("rst_fail_cnt", 32'(dut.fail_cnt_q),  0);
    check_eq("rst_senha_q",  32'(dut.senha_q),     0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    // match at address 5 (duplicate at 20 must not matter)
    request(8'hA7, -1, -1, 50);
    check_eq("t1_addr5",   addr5,  5);
    check_eq("t1_g_edge",  g_edge, 8);
    check_eq("t1_g_len",   g_len,  8);
    check_eq("t1_d_edge",  d_edge, -1);
    check_eq("t1_fail",    32'(dut.fail_cnt_q), 0);
    check_eq("t1_busy",    32'(bus.busy), 0);

    // full miss
    request(8'h3C, -1, -1, 50);
    check_eq("t2_d_edge",  d_edge, 34);
    check_eq("t2_d_len",   d_len,  8);
    check_eq("t2_g_edge",  g_edge, -1);
    check_eq("t2_fail",    32'(dut.fail_cnt_q), 1);

    // extra enters during SCAN and GRANT are dropped
    request(8'hA7, 3, 10, 50);
    check_eq("t3_g_rises", g_rises, 1);
    check_eq("t3_g_edge",  g_edge,  8);
    check_eq("t3_g_len",   g_len,   8);
    check_eq("t3_d_edge",  d_edge,  -1);
    check_eq("t3_busy",    32'(bus.busy), 0);
    check_eq("t3_fail",    32'(dut.fail_cnt_q), 0);

    // last entry, then the empty-entry password
    request(8'h55, -1, -1, 50);
    check_eq("t4_g_edge",  g_edge, 34);
    check_eq("t4_g_len",   g_len,  8);
    request(8'h00, -1, -1, 50);
    check_eq("t4_zero_d",  d_edge, 34);
    check_eq("t4_zero_g",  g_edge, -1);
    check_eq("t4_both",    both,   0);

    // consecutive denials
    request(8'hA7, -1, -1, 50);
    check_eq("t5_pre_g",   g_edge, 8);
    request(8'h3C, -1, -1, 50);
    request(8'h3C, -1, -1, 50);
    check_eq("t5_fail2",   32'(dut.fail_cnt_q), 2);
    request(8'h3C, -1, -1, 50);
    check_eq("t5_d_edge",  d_edge, 34);
    check_eq("t5_fail3",   32'(dut.fail_cnt_q), 3);
`ifdef LOCKOUT_EN
    check_eq("t5_l_edge",  l_edge, 42);
    lock_total  = l_len;
    lock_grants = 0;
    bus.senha   = 8'hA7;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      bus.enter = 1'b0;
      if (bus.granted) lock_grants++;
      if (!bus.locked) break;
      lock_total++;
      if (i == 100) bus.enter = 1'b1;
    end
    check_eq("t5_lock_len",   lock_total,  LOCK_CYCLES);
    check_eq("t5_lock_grant", lock_grants, 0);
    check_eq("t5_lock_busy",  32'(bus.busy), 0);
    check_eq("t5_lock_fail",  32'(dut.fail_cnt_q), 0);
`else
    check_eq("t5_no_lock", l_edge, -1);
    request(8'h3C, -1, -1, 50);
    check_eq("t5_fail_sat", 32'(dut.fail_cnt_q), 3);
`endif
    request(8'hA7, -1, -1, 50);
    check_eq("t5_post_g",  g_edge, 8);
    check_eq("t5_post_f",  32'(dut.fail_cnt_q), 0);

    // async abort mid-scan
    bus.senha = 8'h55;
    bus.enter = 1'b1;
    @(posedge clk); #1;
    bus.enter = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_pre_busy", 32'(bus.busy), 1);
    clr_n = 1'b0;
    #1;
    check_eq("t6_busy",     32'(bus.busy),     0);
    check_eq("t6_rom_addr", 32'(bus.rom_addr), 0);
    check_eq("t6_granted",  32'(bus.granted),  0);
    check_eq("t6_denied",   32'(bus.denied),   0);
    check_eq("t6_locked",   32'(bus.locked),   0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    quiet_hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.granted || bus.denied || bus.busy) quiet_hits++;
    end
    check_eq("t6_quiet",    quiet_hits, 0);
    request(8'hA7, -1, -1, 50);
    check_eq("t6_post_g",   g_edge, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
